pcie_tx_cpl: RTL and testbench

//  Completion transmit engine: sends a one-DW CplD TLP on the 64-bit TRN TX interface for each target memory read.

---
 rtl/pcie_tx_cpl_if.sv | 31 +++
 rtl/pcie_tx_cpl.sv | 180 ++++++++++++++++++
 tb/tb_pcie_tx_cpl.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_tx_cpl_if.sv
// TRN transmit-side signal bundle between the completion engine (master) and
// the link-layer transmit port (slave).
interface pcie_tx_cpl_if;
  logic [63:0] trn_td_o;
  logic [7:0]  trn_trem_n_o;
  logic        trn_tsof_n_o;
  logic        trn_teof_n_o;
  logic        trn_tsrc_rdy_n_o;
  logic        trn_tsrc_dsc_n_o;
  logic        trn_tdst_rdy_n_i;

  modport master (
    output trn_td_o,
    output trn_trem_n_o,
    output trn_tsof_n_o,
    output trn_teof_n_o,
    output trn_tsrc_rdy_n_o,
    output trn_tsrc_dsc_n_o,
    input  trn_tdst_rdy_n_i
  );

  modport slave (
    input  trn_td_o,
    input  trn_trem_n_o,
    input  trn_tsof_n_o,
    input  trn_teof_n_o,
    input  trn_tsrc_rdy_n_o,
    input  trn_tsrc_dsc_n_o,
    output trn_tdst_rdy_n_i
  );
endinterface

// File: rtl/pcie_tx_cpl.sv
// Completion transmit engine: reads one DW from user memory for each target
// memory read and sends it back as a two-beat CplD TLP on the 64-bit TRN bus.
module pcie_tx_cpl #(
  parameter int RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_compl_i,
  input  logic [2:0]           req_tc_i,
  input  logic [1:0]           req_attr_i,
  input  logic [15:0]          req_rid_i,
  input  logic [7:0]           req_tag_i,
  input  logic [3:0]           req_be_i,
  input  logic [12:0]          req_addr_i,
  input  logic [15:0]          completer_id_i,
  output logic [10:0]          rd_addr_o,
  output logic [3:0]           rd_be_o,
  input  logic [31:0]          rd_data_i,
  pcie_tx_cpl_if.master        trn,
  output logic                 compl_done_o,
  output logic [2:0]           dbg_state_o
);

  // Handshake: a beat transfers on the rising edge where trn_tsrc_rdy_n_o and
  // trn_tdst_rdy_n_i are both low; until then the engine holds td/sof/eof/rem
  // unchanged, and it never withdraws a presented beat.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_HDR     = 3'd2,
    S_DATA    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  tc_q, tc_d;
  logic [1:0]  attr_q, attr_d;
  logic [15:0] rid_q, rid_d;
  logic [7:0]  tag_q, tag_d;
  logic [3:0]  be_q, be_d;
  logic [4:0]  lo_addr_q, lo_addr_d;
  logic [15:0] cid_q, cid_d;
  logic [10:0] rd_addr_q, rd_addr_d;
  logic [31:0] data_q, data_d;

  logic [31:0] dw0, dw1, dw2, data_swapped;

  function automatic logic [11:0] byte_count(input logic [3:0] be);
    casez (be)
      4'b1??1:                   byte_count = 12'd4;
      4'b01?1, 4'b1?10:          byte_count = 12'd3;
      4'b0011, 4'b0110, 4'b1100: byte_count = 12'd2;
      default:                   byte_count = 12'd1;
    endcase
  endfunction

  function automatic logic [1:0] low_byte(input logic [3:0] be);
    casez (be)
      4'b???1: low_byte = 2'd0;
      4'b??10: low_byte = 2'd1;
      4'b?100: low_byte = 2'd2;
      4'b1000: low_byte = 2'd3;
      default: low_byte = 2'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tc_q      <= '0;
      attr_q    <= '0;
      rid_q     <= '0;
      tag_q     <= '0;
      be_q      <= '0;
      lo_addr_q <= '0;
      cid_q     <= '0;
      rd_addr_q <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tc_q      <= tc_d;
      attr_q    <= attr_d;
      rid_q     <= rid_d;
      tag_q     <= tag_d;
      be_q      <= be_d;
      lo_addr_q <= lo_addr_d;
      cid_q     <= cid_d;
      rd_addr_q <= rd_addr_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tc_d      = tc_q;
    attr_d    = attr_q;
    rid_d     = rid_q;
    tag_d     = tag_q;
    be_d      = be_q;
    lo_addr_d = lo_addr_q;
    cid_d     = cid_q;
    rd_addr_d = rd_addr_q;
    data_d    = data_q;
    case (state_q)
      S_IDLE: begin
        if (req_compl_i) begin
          tc_d      = req_tc_i;
          attr_d    = req_attr_i;
          rid_d     = req_rid_i;
          tag_d     = req_tag_i;
          be_d      = req_be_i;
          lo_addr_d = req_addr_i[6:2];
          cid_d     = completer_id_i;
          rd_addr_d = req_addr_i[12:2];
          cnt_d     = 3'(RD_LATENCY);
          state_d   = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // Memory data becomes valid RD_LATENCY clocks after the address; it is
        // sampled on the edge where the counter has run out.
        if (cnt_q == 3'd0) begin
          data_d  = rd_data_i;
          state_d = S_HDR;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_HDR: begin
        if (!trn.trn_tdst_rdy_n_i) state_d = S_DATA;
      end
      S_DATA: begin
        if (!trn.trn_tdst_rdy_n_i) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign dw0 = {1'b0, 2'b10, 5'b01010, 1'b0, tc_q, 4'b0000, 1'b0, 1'b0,
                attr_q, 2'b00, 10'd1};
  assign dw1 = {cid_q, 3'b000, 1'b0, byte_count(be_q)};
  assign dw2 = {rid_q, tag_q, 1'b0, lo_addr_q, low_byte(be_q)};
  assign data_swapped = {data_q[7:0], data_q[15:8], data_q[23:16], data_q[31:24]};

  // Outputs decode straight from the state flops so an async reset returns
  // them to idle values without waiting for a clock.
  always_comb begin
    trn.trn_td_o         = '0;
    trn.trn_trem_n_o     = 8'h00;
    trn.trn_tsof_n_o     = 1'b1;
    trn.trn_teof_n_o     = 1'b1;
    trn.trn_tsrc_rdy_n_o = 1'b1;
    trn.trn_tsrc_dsc_n_o = 1'b1;
    compl_done_o         = 1'b0;
    case (state_q)
      S_HDR: begin
        trn.trn_td_o         = {dw0, dw1};
        trn.trn_tsof_n_o     = 1'b0;
        trn.trn_tsrc_rdy_n_o = 1'b0;
      end
      S_DATA: begin
        trn.trn_td_o         = {dw2, data_swapped};
        trn.trn_teof_n_o     = 1'b0;
        trn.trn_tsrc_rdy_n_o = 1'b0;
      end
      S_DONE:  compl_done_o = 1'b1;
      default: ;
    endcase
  end

  assign rd_addr_o   = rd_addr_q;
  assign rd_be_o     = be_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pcie_tx_cpl.sv
// Bench for pcie_tx_cpl: three instances (read latency 2, 1 and 7) driven in
// lock-step and checked beat by beat against a field-level completion model.
module tb_pcie_tx_cpl;
  localparam int NI = 3;

  function automatic int lat_of(input int g);
    case (g)
      0:       lat_of = 2;
      1:       lat_of = 1;
      default: lat_of = 7;
    endcase
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus signals ----------------
  logic        req_compl [NI];
  logic [2:0]  req_tc;
  logic [1:0]  req_attr;
  logic [15:0] req_rid, cid;
  logic [7:0]  req_tag;
  logic [3:0]  req_be;
  logic [12:0] req_addr;
  logic        dst_rdy_n;
  int          dst_mode;
  logic [31:0] mem [2048];

  // ---------------- scoreboard ----------------
  logic [65:0] exp_q   [NI][$];
  logic [14:0] exp_a_q [NI][$];
  int done_cnt [NI];
  int want [NI];
  int t_req [NI];
  int last_done [NI];
  bit b2b;
  int n_vec = 0;
  int n_err = 0;

  logic [NI-1:0][63:0] td_w;
  logic [NI-1:0][7:0]  trem_w;
  logic [NI-1:0]       sof_w, eof_w, src_w, dsc_w, done_w;
  logic [NI-1:0][10:0] rd_addr_w;
  logic [NI-1:0][3:0]  rd_be_w;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- DUTs, memories, monitors ----------------
  for (genvar g = 0; g < NI; g++) begin : g_inst
    pcie_tx_cpl_if bus ();
    logic [10:0] rd_addr;
    logic [3:0]  rd_be;
    logic [31:0] rd_data;
    logic        done;
    logic [2:0]  dbg_state;
    logic [31:0] pipe [8];

    assign bus.trn_tdst_rdy_n_i = dst_rdy_n;
    assign rd_data = pipe[lat_of(g) - 1];
    always @(posedge clk) begin
      pipe[0] <= mem[rd_addr];
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end

    pcie_tx_cpl #(.RD_LATENCY(lat_of(g))) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_compl_i    (req_compl[g]),
      .req_tc_i       (req_tc),
      .req_attr_i     (req_attr),
      .req_rid_i      (req_rid),
      .req_tag_i      (req_tag),
      .req_be_i       (req_be),
      .req_addr_i     (req_addr),
      .completer_id_i (cid),
      .rd_addr_o      (rd_addr),
      .rd_be_o        (rd_be),
      .rd_data_i      (rd_data),
      .trn            (bus.master),
      .compl_done_o   (done),
      .dbg_state_o    (dbg_state)
    );

    assign td_w[g]      = bus.trn_td_o;
    assign trem_w[g]    = bus.trn_trem_n_o;
    assign sof_w[g]     = bus.trn_tsof_n_o;
    assign eof_w[g]     = bus.trn_teof_n_o;
    assign src_w[g]     = bus.trn_tsrc_rdy_n_o;
    assign dsc_w[g]     = bus.trn_tsrc_dsc_n_o;
    assign done_w[g]    = done;
    assign rd_addr_w[g] = rd_addr;
    assign rd_be_w[g]   = rd_be;

    logic [65:0] held, e;
    logic [14:0] ea;
    bit stalled, data_acc, prev_hdr, valid, acc, hdr_now;
    always @(negedge clk) begin
      if (!rst_n) begin
        stalled  = 0;
        data_acc = 0;
        prev_hdr = 0;
      end else begin
        valid = (bus.trn_tsrc_rdy_n_o == 1'b0);
        acc   = valid && (dst_rdy_n == 1'b0);
        if (stalled)
          check($sformatf("hold_i%0d", g),
                {bus.trn_tsof_n_o, bus.trn_teof_n_o, bus.trn_td_o}, held);
        stalled = valid && dst_rdy_n;
        held = {bus.trn_tsof_n_o, bus.trn_teof_n_o, bus.trn_td_o};
        check($sformatf("done_i%0d", g), 66'(done), 66'(data_acc));
        if (done) begin
          done_cnt[g]++;
          last_done[g] = cyc;
          if (done_cnt[g] >= want[g]) req_compl[g] = 1'b0;
        end
        data_acc = acc && !bus.trn_teof_n_o;
        hdr_now = valid && !bus.trn_tsof_n_o;
        if (hdr_now && !prev_hdr) begin
          if (t_req[g] >= 0) begin
            check($sformatf("hdr_lat_i%0d", g), 66'(cyc - t_req[g]), 66'(lat_of(g) + 1));
            t_req[g] = -1;
          end else if (b2b && last_done[g] >= 0) begin
            check($sformatf("b2b_gap_i%0d", g), 66'(cyc - last_done[g]), 66'(lat_of(g) + 3));
          end
        end
        prev_hdr = hdr_now;
        if (acc) begin
          if (exp_q[g].size() == 0) begin
            check($sformatf("extra_beat_i%0d", g), 66'(1), 66'(0));
          end else begin
            e = exp_q[g].pop_front();
            check($sformatf("beat_i%0d", g),
                  {bus.trn_tsof_n_o, bus.trn_teof_n_o, bus.trn_td_o}, e);
            check($sformatf("trem_i%0d", g), 66'(bus.trn_trem_n_o), 66'(0));
            if (!bus.trn_tsof_n_o && exp_a_q[g].size() != 0) begin
              ea = exp_a_q[g].pop_front();
              check($sformatf("rd_addr_i%0d", g), 66'({rd_addr, rd_be}), 66'(ea));
            end
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int lowest_be(input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) return i;
    return -1;
  endfunction

  function automatic int highest_be(input logic [3:0] be);
    for (int i = 3; i >= 0; i--) if (be[i]) return i;
    return -1;
  endfunction

  task automatic push_expected();
    int lo, hi, bc, la;
    logic [31:0] dw0, dw1, dw2, d, sw;
    lo = lowest_be(req_be);
    hi = highest_be(req_be);
    bc = (lo < 0) ? 1 : hi - lo + 1;
    la = (lo < 0) ? 0 : lo;
    dw0 = 32'h4A00_0001 + (32'(req_tc) << 20) + (32'(req_attr) << 12);
    dw1 = (32'(cid) << 16) + 32'(bc);
    dw2 = (32'(req_rid) << 16) + (32'(req_tag) << 8) + 32'(req_addr & 13'h7C) + 32'(la);
    d   = mem[req_addr[12:2]];
    sw  = {<<8{d}};
    for (int g = 0; g < NI; g++) begin
      exp_q[g].push_back({1'b0, 1'b1, dw0, dw1});
      exp_q[g].push_back({1'b1, 1'b0, dw2, sw});
      exp_a_q[g].push_back({req_addr[12:2], req_be});
    end
  endtask

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    if (dst_mode == 0) dst_rdy_n = 1'b0;
    else if (dst_mode == 1) dst_rdy_n = ($urandom_range(0, 2) == 0);
  end

  task automatic set_fields(input logic [2:0] tc, input logic [1:0] attr, input logic [15:0] rid,
                            input logic [7:0] tag, input logic [3:0] be, input logic [12:0] addr,
                            input logic [15:0] c);
    req_tc = tc; req_attr = attr; req_rid = rid; req_tag = tag;
    req_be = be; req_addr = addr; cid = c;
  endtask

  task automatic rand_fields();
    set_fields(3'($urandom), 2'($urandom), 16'($urandom), 8'($urandom),
               4'($urandom), 13'($urandom), 16'($urandom));
  endtask

  task automatic send(input int n, input bit change);
    bit all;
    b2b = (n > 1);
    for (int g = 0; g < NI; g++) begin
      want[g] = n; done_cnt[g] = 0; last_done[g] = -1;
    end
    push_expected();
    @(posedge clk); #1;
    for (int g = 0; g < NI; g++) begin
      req_compl[g] = 1'b1;
      t_req[g] = cyc + 1;
    end
    if (n > 1) begin
      @(posedge clk); #1;
      if (change) rand_fields();
      push_expected();
    end
    all = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      all = 1;
      for (int g = 0; g < NI; g++)
        if (done_cnt[g] < want[g] || exp_q[g].size() != 0) all = 0;
      if (all) break;
    end
    if (!all) check("timeout", 66'(0), 66'(1));
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("done_count_i%0d", g), 66'(done_cnt[g]), 66'(want[g]));
      req_compl[g] = 1'b0;
      exp_q[g].delete();
      exp_a_q[g].delete();
    end
    b2b = 0;
  endtask

  task automatic wait_hdr0();
    bit seen;
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (!sof_w[0] && !src_w[0]) seen = 1;
    end
    if (!seen) check("hdr_wait_timeout", 66'(0), 66'(1));
  endtask

  task automatic stall_seq();
    wait_hdr0();
    repeat (5) @(posedge clk);
    #1 dst_rdy_n = 1'b0;
    @(posedge clk); #1 dst_rdy_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 dst_rdy_n = 1'b0;
    dst_mode = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s_td_i%0d", tag, g), 66'(td_w[g]), 66'(0));
      check($sformatf("%s_ctl_i%0d", tag, g),
            66'({sof_w[g], eof_w[g], src_w[g], dsc_w[g], done_w[g], trem_w[g]}),
            66'({1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00}));
      check($sformatf("%s_rd_i%0d", tag, g), 66'({rd_addr_w[g], rd_be_w[g]}), 66'(0));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    for (int g = 0; g < NI; g++) begin
      req_compl[g] = 1'b0; t_req[g] = -1; want[g] = 1; done_cnt[g] = 0; last_done[g] = -1;
    end
    b2b = 0;
    dst_mode = 0;
    dst_rdy_n = 1'b0;
    set_fields(3'd0, 2'd0, 16'h0, 8'h0, 4'h0, 13'h0, 16'h0);
    repeat (3) @(posedge clk);
    #2 check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Reference TLP: 0x4A000001_02000004 / 0x01000524_44332211
    mem[9] = 32'h1122_3344;
    set_fields(3'd0, 2'd0, 16'h0100, 8'h05, 4'hF, 13'h0024, 16'h0200);
    send(1, 0);

    // Partial byte enables
    set_fields(3'd0, 2'd0, 16'h0100, 8'h06, 4'h6, 13'h0040, 16'h0200);
    send(1, 0);
    set_fields(3'd0, 2'd0, 16'h0100, 8'h07, 4'h8, 13'h0040, 16'h0200);
    send(1, 0);
    set_fields(3'd5, 2'd3, 16'hBEEF, 8'hA5, 4'h0, 13'h1FFF, 16'hFFFF);
    send(1, 0);

    // Randomised traffic with random destination back-pressure
    dst_mode = 1;
    for (int k = 0; k < 16; k++) begin
      rand_fields();
      send(1, 0);
    end

    // Fixed stalls: 5 cycles in HDR, 3 in DATA
    dst_mode = 2;
    dst_rdy_n = 1'b1;
    rand_fields();
    fork
      send(1, 0);
      stall_seq();
    join

    // Request held across two completions, fields changed while busy
    dst_mode = 0;
    rand_fields();
    send(2, 1);
    dst_mode = 1;
    rand_fields();
    send(2, 1);

    // Async reset while instance 0 sits in DATA
    dst_mode = 2;
    dst_rdy_n = 1'b1;
    rand_fields();
    for (int g = 0; g < NI; g++) begin
      done_cnt[g] = 0; want[g] = 1; last_done[g] = -1;
    end
    push_expected();
    @(posedge clk); #1;
    for (int g = 0; g < NI; g++) req_compl[g] = 1'b1;
    wait_hdr0();
    @(posedge clk); #1 dst_rdy_n = 1'b0;
    @(posedge clk); #1 dst_rdy_n = 1'b1;
    @(negedge clk);
    check("rst_pre_data_i0", 66'({eof_w[0], src_w[0]}), 66'(0));
    @(posedge clk); #3 rst_n = 1'b0;
    #1 check_idle_outputs("async_rst");
    for (int g = 0; g < NI; g++) begin
      req_compl[g] = 1'b0;
      t_req[g] = -1;
      exp_q[g].delete();
      exp_a_q[g].delete();
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    dst_mode = 0;
    repeat (4) @(negedge clk);
    for (int g = 0; g < NI; g++)
      check($sformatf("no_done_after_rst_i%0d", g), 66'(done_cnt[g]), 66'(0));
    rand_fields();
    send(1, 0);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "simulation time limit");
  end
endmodule
